// File: rtl/expr_emit.sv
//==============================================================================
// Module      : expr_emit
// Description : Serializes BCD operands and +/* operators into an ASCII stream,
//               one character per clock. Optional macro EXPR_EMIT_STALL_EN adds
//               a stall input that re-presents the current character.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module expr_emit #(
    parameter int MAX_TERMS = 8
) (
    input  logic                         clk,
    input  logic                         clr,
`ifdef EXPR_EMIT_STALL_EN
    input  logic                         stall,
`endif
    input  logic                         start,
    input  logic [$clog2(MAX_TERMS)-1:0] count,
    input  logic [4*MAX_TERMS-1:0]       digits,
    input  logic [MAX_TERMS-2:0]         ops,
    output logic                         ready,
    output logic [7:0]                   out_char,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int c_CW = $clog2(MAX_TERMS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIGIT = 2'd1,
        S_OP    = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_nstate;
    logic [c_CW-1:0]        r_idx;
    logic [c_CW-1:0]        w_nidx;
    logic [c_CW-1:0]        r_count;
    logic [4*MAX_TERMS-1:0] r_digits;
    logic [MAX_TERMS-2:0]   r_ops;
    logic [7:0]             r_out_char;
    logic [7:0]             w_nchar;
    logic                   r_out_valid;
    logic                   w_nvalid;
    logic                   r_busy;
    logic                   r_ready;
    logic                   r_done;
    logic                   r_err;
    logic                   w_nerr;
    logic                   w_accept;
    logic                   w_stall;
    logic [MAX_TERMS-1:0]   w_bad_vec;

`ifdef EXPR_EMIT_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Only terms that will actually be emitted are checked for valid BCD.
    for (genvar gi = 0; gi < MAX_TERMS; gi++) begin : g_chk
        assign w_bad_vec[gi] = (count >= c_CW'(gi)) && (digits[4*gi +: 4] > 4'd9);
    end

    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        w_nchar  = 8'h00;
        w_nvalid = 1'b0;
        w_nerr   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_ready gates the cycle right after DONE, when ready is still low.
                if (start && r_ready) begin
                    if (|w_bad_vec) begin
                        w_nerr = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_nstate = S_DIGIT;
                        w_nidx   = '0;
                    end
                end
            end
            S_DIGIT: begin
                w_nchar  = {4'h3, r_digits[{r_idx, 2'b00} +: 4]};
                w_nvalid = 1'b1;
                w_nstate = (r_idx == r_count) ? S_DONE : S_OP;
            end
            S_OP: begin
                w_nchar  = r_ops[r_idx] ? 8'h2A : 8'h2B;
                w_nvalid = 1'b1;
                w_nidx   = r_idx + c_CW'(1);
                w_nstate = S_DIGIT;
            end
            S_DONE: begin
                w_nstate = S_IDLE;
            end
            default: begin
                w_nstate = S_IDLE;
            end
        endcase
        if (w_stall && (r_state == S_DIGIT || r_state == S_OP)) begin
            w_nstate = r_state;
            w_nidx   = r_idx;
            w_nchar  = r_out_char;
            w_nvalid = r_out_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_digits    <= '0;
            r_ops       <= '0;
            r_out_char  <= 8'h00;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_idx       <= w_nidx;
            if (w_accept) begin
                r_count  <= count;
                r_digits <= digits;
                r_ops    <= ops;
            end
            r_out_char  <= w_nchar;
            r_out_valid <= w_nvalid;
            r_err       <= w_nerr;
            r_done      <= (r_state == S_DONE);
            r_busy      <= (r_state == S_DIGIT) || (r_state == S_OP);
            r_ready     <= (r_state == S_IDLE);
        end
    end

    assign ready     = r_ready;
    assign out_char  = r_out_char;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_expr_emit.sv
//==============================================================================
// Module      : tb_expr_emit
// Description : Self-checking bench for expr_emit against an output-timeline model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_expr_emit;

    localparam int c_MT = 8;

    typedef struct packed {
        logic [7:0] ch;
        logic       valid;
        logic       busy;
        logic       ready;
        logic       done;
        logic       err;
    } vec_t;

    localparam vec_t c_IDLE = '{ch: 8'h00, valid: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0, err: 1'b0};

    logic                clk = 1'b0;
    logic                clr = 1'b1;
    logic                start = 1'b0;
    logic [2:0]          count = '0;
    logic [4*c_MT-1:0]   digits = '0;
    logic [c_MT-2:0]     ops = '0;
    logic                ready;
    logic [7:0]          out_char;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic                err;
`ifdef EXPR_EMIT_STALL_EN
    logic                stall = 1'b0;
`endif

    expr_emit #(.MAX_TERMS(c_MT)) dut (
        .clk       (clk),
        .clr       (clr),
`ifdef EXPR_EMIT_STALL_EN
        .stall     (stall),
`endif
        .start     (start),
        .count     (count),
        .digits    (digits),
        .ops       (ops),
        .ready     (ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         mark = 0;
    int         done_at = -1;
    int         err_seen = 0;
    vec_t       cur = c_IDLE;
    vec_t       q[$];
    logic [7:0] cap[$];

    // Expected outputs for each cycle following an accepted start.
    task automatic model_edge();
        logic bad;
        int   n;
        vec_t v;
        if (clr) begin
            q.delete();
            cur = c_IDLE;
            return;
        end
        if (start && cur.ready && q.size() == 0) begin
            bad = 1'b0;
            for (int i = 0; i <= int'(count); i++)
                if (digits[4*i +: 4] > 4'd9) bad = 1'b1;
            if (bad) begin
                v = c_IDLE; v.err = 1'b1;
                q.push_back(v);
            end else begin
                n = int'(count) + 1;
                q.push_back(c_IDLE);
                for (int j = 0; j < 2*n-1; j++) begin
                    v = '{ch: 8'h00, valid: 1'b1, busy: 1'b1, ready: 1'b0, done: 1'b0, err: 1'b0};
                    if (j % 2 == 0) v.ch = 8'h30 + 8'(digits[4*(j/2) +: 4]);
                    else            v.ch = ops[j/2] ? 8'h2A : 8'h2B;
                    q.push_back(v);
                end
                v = '{ch: 8'h00, valid: 1'b0, busy: 1'b0, ready: 1'b0, done: 1'b1, err: 1'b0};
                q.push_back(v);
            end
        end
        cur = (q.size() != 0) ? q.pop_front() : c_IDLE;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0d got=0x%0h expected=0x%0h", name, cyc, got, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT is compared at the falling edge.
    task automatic step();
        vec_t d;
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        d = '{ch: out_char, valid: out_valid, busy: busy, ready: ready, done: done, err: err};
        chk("cycle_outputs", int'(d), int'(cur));
        if (out_valid) cap.push_back(out_char);
        if (done && done_at < 0) done_at = cyc - mark;
        if (err) err_seen++;
    endtask

    task automatic launch(input logic [2:0] c, input logic [31:0] dg, input logic [6:0] op);
        count = c; digits = dg; ops = op; start = 1'b1;
        cap.delete(); done_at = -1; err_seen = 0;
        step();
        mark = cyc;
        start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        step();
        clr = 1'b0;
        chk("reset_ready", int'(ready), 1);
        chk("reset_char", int'(out_char), 0);
        chk("reset_valid", int'(out_valid), 0);

        // single digit
        launch(3'd0, 32'h0000_0007, 7'd0);
        repeat (4) step();
        chk("t1_len", cap.size(), 1);
        if (cap.size() == 1) chk("t1_char", int'(cap[0]), 'h37);
        chk("t1_done_at", done_at, 2);
        chk("t1_ready_after", int'(ready), 1);

        // three terms
        launch(3'd2, 32'h0000_0953, 7'b0000010);
        repeat (8) step();
        chk("t2_len", cap.size(), 5);
        if (cap.size() == 5) begin
            chk("t2_c0", int'(cap[0]), 'h33);
            chk("t2_c1", int'(cap[1]), 'h2B);
            chk("t2_c2", int'(cap[2]), 'h35);
            chk("t2_c3", int'(cap[3]), 'h2A);
            chk("t2_c4", int'(cap[4]), 'h39);
        end
        chk("t2_done_at", done_at, 6);

        // bad BCD in a used term, then in an unused term
        launch(3'd1, 32'h0000_00A3, 7'd0);
        repeat (2) step();
        chk("t3_err_seen", err_seen, 1);
        chk("t3_no_chars", cap.size(), 0);
        launch(3'd0, 32'h0000_00F2, 7'd0);
        repeat (4) step();
        chk("t3b_err_seen", err_seen, 0);
        chk("t3b_len", cap.size(), 1);

        // start ignored while busy, then clr truncates the stream
        launch(3'd2, 32'h0000_0953, 7'b0000010);
        step();
        step();
        start = 1'b1; digits = 32'h0000_0111;
        step();
        start = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_valid_after_clr", int'(out_valid), 0);
        chk("t4_ready_after_clr", int'(ready), 1);
        repeat (10) step();
        chk("t4_no_done", done_at, -1);
        chk("t4_len", cap.size(), 3);

        // full-length expression
        launch(3'd7, 32'h9999_9999, 7'b1010101);
        repeat (20) step();
        chk("t5_len", cap.size(), 15);
        if (cap.size() == 15) chk("t5_last", int'(cap[14]), 'h39);
        chk("t5_done_at", done_at, 16);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            clr   = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 2) == 0);
            count = 3'($urandom_range(0, 7));
            for (int i = 0; i < c_MT; i++)
                digits[4*i +: 4] = 4'($urandom_range(0, 9) + (($urandom_range(0, 15) == 0) ? 6 : 0));
            ops = 7'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
